// File: rtl/ascon_sbox_layer_seq.sv
// ascon_sbox_layer_seq: sequential ASCON substitution layer.
// Loads a 320-bit state (x0..x4) and runs LANES 5-bit S-boxes per cycle over
// the 64 bit-columns, rotating the working words right by LANES each cycle so
// that after 64/LANES cycles every word holds its result in original order.
// Optional feature macro: ASCON_SBOX_BYPASS_EN adds a bypass input, captured
// with the load handshake, that passes the state through unsubstituted.
//
// state | meaning
// IDLE  | waiting for a state, in_ready=1
// RUN   | substituting LANES columns per cycle
// DONE  | result held on y0..y4, out_valid=1 until out_ready
module ascon_sbox_layer_seq #(
    parameter int LANES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    input  logic [63:0] x2,
    input  logic [63:0] x3,
    input  logic [63:0] x4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] y0,
    output logic [63:0] y1,
    output logic [63:0] y2,
    output logic [63:0] y3,
    output logic [63:0] y4,
    output logic        busy
`ifdef ASCON_SBOX_BYPASS_EN
    ,
    input  logic        bypass
`endif
);

    localparam int STEPS = 64 / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [63:0]      w0, w1, w2, w3, w4;
    logic [63:0]      n0, n1, n2, n3, n4;
    logic [LANES-1:0] s0, s1, s2, s3, s4;
    logic [4:0]       col, res;
`ifdef ASCON_SBOX_BYPASS_EN
    logic             byp_q;
`endif

    // Bitsliced ASCON S-box; index/result ordered {x0,x1,x2,x3,x4}.
    function automatic logic [4:0] sbox5(input logic [4:0] v);
        logic a0, a1, a2, a3, a4;
        logic t0, t1, t2, t3, t4;
        a0 = v[4]; a1 = v[3]; a2 = v[2]; a3 = v[1]; a4 = v[0];
        a0 = a0 ^ a4; a4 = a4 ^ a3; a2 = a2 ^ a1;
        t0 = ~a0 & a1; t1 = ~a1 & a2; t2 = ~a2 & a3; t3 = ~a3 & a4; t4 = ~a4 & a0;
        a0 = a0 ^ t1; a1 = a1 ^ t2; a2 = a2 ^ t3; a3 = a3 ^ t4; a4 = a4 ^ t0;
        a1 = a1 ^ a0; a0 = a0 ^ a4; a3 = a3 ^ a2; a2 = ~a2;
        return {a0, a1, a2, a3, a4};
    endfunction

    // Substitute the low LANES columns and form the rotated next words.
    always_comb begin
        s0 = '0; s1 = '0; s2 = '0; s3 = '0; s4 = '0;
        col = '0;
        res = '0;
        for (int j = 0; j < LANES; j++) begin
            col = {w0[j], w1[j], w2[j], w3[j], w4[j]};
`ifdef ASCON_SBOX_BYPASS_EN
            res = byp_q ? col : sbox5(col);
`else
            res = sbox5(col);
`endif
            s0[j] = res[4];
            s1[j] = res[3];
            s2[j] = res[2];
            s3[j] = res[1];
            s4[j] = res[0];
        end
        n0 = w0 >> LANES; n0[63 -: LANES] = s0;
        n1 = w1 >> LANES; n1[63 -: LANES] = s1;
        n2 = w2 >> LANES; n2[63 -: LANES] = s2;
        n3 = w3 >> LANES; n3[63 -: LANES] = s3;
        n4 = w4 >> LANES; n4[63 -: LANES] = s4;
    end

    // Control FSM, step counter and working registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            w0 <= '0; w1 <= '0; w2 <= '0; w3 <= '0; w4 <= '0;
`ifdef ASCON_SBOX_BYPASS_EN
            byp_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        w0 <= x0; w1 <= x1; w2 <= x2; w3 <= x3; w4 <= x4;
                        cnt   <= '0;
`ifdef ASCON_SBOX_BYPASS_EN
                        byp_q <= bypass;
`endif
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    w0 <= n0; w1 <= n1; w2 <= n2; w3 <= n3; w4 <= n4;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from the registered state.
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        busy      = (state == S_RUN) || (state == S_DONE);
        y0 = w0; y1 = w1; y2 = w2; y3 = w3; y4 = w4;
    end

endmodule

// File: tb/tb_ascon_sbox_layer_seq.sv
// Testbench for ascon_sbox_layer_seq: four instances (LANES 1, 8, 16, 64)
// checked against a table-driven column model of the ASCON S-box layer.
module tb_ascon_sbox_layer_seq;

    typedef logic [4:0][63:0] st_t;

    localparam logic [7:0] SBOX_TBL [32] = '{
        8'h04, 8'h0b, 8'h1f, 8'h14, 8'h1a, 8'h15, 8'h09, 8'h02,
        8'h1b, 8'h05, 8'h08, 8'h12, 8'h1d, 8'h03, 8'h06, 8'h1c,
        8'h1e, 8'h13, 8'h07, 8'h0e, 8'h00, 8'h0d, 8'h11, 8'h18,
        8'h10, 8'h0c, 8'h01, 8'h19, 8'h16, 8'h0a, 8'h0f, 8'h17};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        in_valid_a  [4];
    logic        out_ready_a [4];
    logic        bypass_a    [4];
    logic [63:0] x_a         [4][5];
    wire         in_ready_a  [4];
    wire         out_valid_a [4];
    wire         busy_a      [4];
    wire  [63:0] y_a         [4][5];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LN = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 16 : 64;
        ascon_sbox_layer_seq #(.LANES(LN)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .x0        (x_a[g][0]),
            .x1        (x_a[g][1]),
            .x2        (x_a[g][2]),
            .x3        (x_a[g][3]),
            .x4        (x_a[g][4]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .y0        (y_a[g][0]),
            .y1        (y_a[g][1]),
            .y2        (y_a[g][2]),
            .y3        (y_a[g][3]),
            .y4        (y_a[g][4]),
`ifdef ASCON_SBOX_BYPASS_EN
            .bypass    (bypass_a[g]),
`endif
            .busy      (busy_a[g])
        );
    end

    function automatic int steps_of(int g);
        case (g)
            0:       return 64;
            1:       return 8;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    // Column-wise table lookup over the whole 320-bit state.
    function automatic st_t ref_model(st_t x, bit byp);
        st_t y;
        logic [4:0] idx;
        logic [7:0] s;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            idx = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
            s = byp ? {3'b000, idx} : SBOX_TBL[idx];
            y[0][i] = s[4]; y[1][i] = s[3]; y[2][i] = s[2];
            y[3][i] = s[1]; y[4][i] = s[0];
        end
        return y;
    endfunction

    function automatic st_t rand_state();
        st_t r;
        for (int w = 0; w < 5; w++) r[w] = {$urandom, $urandom};
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic st_t get_y(int g);
        st_t r;
        for (int w = 0; w < 5; w++) r[w] = y_a[g][w];
        return r;
    endfunction

    task automatic check_idle(input string tag, input int g, input logic [319:0] exp_y);
        check_eq({tag, "_in_ready"}, 320'(in_ready_a[g]), 320'(1));
        check_eq({tag, "_out_valid"}, 320'(out_valid_a[g]), 320'(0));
        check_eq({tag, "_busy"}, 320'(busy_a[g]), 320'(0));
        check_eq({tag, "_y"}, get_y(g), exp_y);
    endtask

    // Present a state and hold in_valid for exactly the accepting edge.
    task automatic do_accept(input int g, input st_t xs, input bit byp);
        @(negedge clk);
        check_eq("accept_in_ready", 320'(in_ready_a[g]), 320'(1));
        for (int w = 0; w < 5; w++) x_a[g][w] = xs[w];
        bypass_a[g]   = byp;
        in_valid_a[g] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_a[g] = 1'b0;
        bypass_a[g]   = ~byp;
        for (int w = 0; w < 5; w++) x_a[g][w] = {$urandom, $urandom};
        check_eq("accept_busy", 320'(busy_a[g]), 320'(1));
        check_eq("accept_not_ready", 320'(in_ready_a[g]), 320'(0));
    endtask

    // Called at the negedge after the accepting edge; checks latency and result.
    task automatic wait_done(input int g, input st_t exp);
        int lat;
        lat = 0;
        while (out_valid_a[g] !== 1'b1 && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq("latency", 320'(lat), 320'(steps_of(g)));
        check_eq("result", get_y(g), exp);
        check_eq("done_busy", 320'(busy_a[g]), 320'(1));
    endtask

    task automatic do_release(input int g, input int hold);
        repeat (hold) @(negedge clk);
        out_ready_a[g] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_a[g] = 1'b0;
        check_eq("release_in_ready", 320'(in_ready_a[g]), 320'(1));
        check_eq("release_out_valid", 320'(out_valid_a[g]), 320'(0));
    endtask

    task automatic run_one(input int g, input st_t xs, input bit byp);
        do_accept(g, xs, byp);
        wait_done(g, ref_model(xs, byp));
        do_release(g, $urandom_range(0, 3));
    endtask

    initial begin
        st_t xa, xb, ea, eb;
        for (int g = 0; g < 4; g++) begin
            in_valid_a[g] = 1'b0; out_ready_a[g] = 1'b0; bypass_a[g] = 1'b0;
            for (int w = 0; w < 5; w++) x_a[g][w] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 4; g++) check_idle("reset", g, 320'(0));
        rst = 1'b0;

        // Directed cases.
        xa = '0;
        ea = '0; ea[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_accept(1, xa, 1'b0);
        wait_done(1, ea);
        do_release(1, 0);

        xa = {5{64'hFFFF_FFFF_FFFF_FFFF}};
        ea = {5{64'hFFFF_FFFF_FFFF_FFFF}}; ea[1] = '0;
        do_accept(1, xa, 1'b0);
        wait_done(1, ea);
        do_release(1, 1);

        for (int g = 0; g < 4; g++) begin
            if (g == 1) continue;
            xa = '0; xa[0] = 64'h1;
            ea = '0;
            ea[2] = 64'hFFFF_FFFF_FFFF_FFFF;
            ea[0] = 64'h1; ea[1] = 64'h1; ea[3] = 64'h1;
            do_accept(g, xa, 1'b0);
            wait_done(g, ea);
            do_release(g, 0);
        end

        // Backpressure: 20 cycles stalled in DONE with a competing in_valid.
        xa = rand_state(); xb = rand_state();
        ea = ref_model(xa, 1'b0); eb = ref_model(xb, 1'b0);
        do_accept(1, xa, 1'b0);
        wait_done(1, ea);
        for (int w = 0; w < 5; w++) x_a[1][w] = xb[w];
        bypass_a[1]   = 1'b0;
        in_valid_a[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("bp_y_stable", get_y(1), ea);
            check_eq("bp_in_ready", 320'(in_ready_a[1]), 320'(0));
            check_eq("bp_out_valid", 320'(out_valid_a[1]), 320'(1));
        end
        out_ready_a[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_a[1] = 1'b0;
        check_eq("bp_ready_after", 320'(in_ready_a[1]), 320'(1));
        check_eq("bp_no_early_accept", 320'(busy_a[1]), 320'(0));
        @(posedge clk);
        @(negedge clk);
        in_valid_a[1] = 1'b0;
        check_eq("bp_second_accept", 320'(busy_a[1]), 320'(1));
        wait_done(1, eb);
        do_release(1, 0);

        // Reset at RUN step 3.
        do_accept(1, rand_state(), 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("midrun_reset", 1, 320'(0));
        run_one(1, rand_state(), 1'b0);

`ifdef ASCON_SBOX_BYPASS_EN
        xa = rand_state();
        do_accept(1, xa, 1'b1);
        wait_done(1, xa);
        do_release(1, 0);
        run_one(1, rand_state(), 1'b0);
`endif

        // Randomized states across all lane widths.
        for (int k = 0; k < 12; k++) begin
            bit byp;
            byp = 1'b0;
`ifdef ASCON_SBOX_BYPASS_EN
            byp = 1'($urandom_range(0, 1));
`endif
            run_one(int'($urandom_range(0, 3)), rand_state(), byp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
